ripple_count_reader: RTL



---
 rtl/ripple_count_reader.sv | 110 +++++++++++
 1 files changed

// File: rtl/ripple_count_reader.sv
// Synchronizes and debounces the bus of an asynchronous ripple counter, publishing only settled counts.
// Define RIPPLE_GLITCH_COUNT_EN to add the glitch_cnt output (candidates abandoned before acceptance).
module ripple_count_reader #(
    parameter int WIDTH         = 4,
    parameter int STABLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] cnt_in,
    output logic [WIDTH-1:0] count_out,
    output logic             update,
    output logic [WIDTH-1:0] delta,
    output logic             wrap
`ifdef RIPPLE_GLITCH_COUNT_EN
    ,
    output logic [7:0]       glitch_cnt
`endif
);

    localparam logic [3:0] STAB = 4'(STABLE_CYCLES);

    logic [WIDTH-1:0] s1_q, s1_d;
    logic [WIDTH-1:0] s2_q, s2_d;
    logic [WIDTH-1:0] cand_q, cand_d;
    logic [3:0]       stab_q, stab_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] delta_q, delta_d;
    logic             update_q, update_d;
    logic             wrap_q, wrap_d;
`ifdef RIPPLE_GLITCH_COUNT_EN
    logic [7:0]       glitch_q, glitch_d;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction
`endif

    function automatic logic [WIDTH-1:0] mod_diff(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        return a - b;
    endfunction

    always_comb begin
        s1_d     = cnt_in;
        s2_d     = s1_q;
        cand_d   = cand_q;
        stab_d   = stab_q;
        count_d  = count_q;
        delta_d  = delta_q;
        update_d = 1'b0;
        wrap_d   = 1'b0;
`ifdef RIPPLE_GLITCH_COUNT_EN
        glitch_d = glitch_q;
`endif
        if (s2_q != cand_q) begin
            cand_d = s2_q;
            stab_d = 4'd0;
`ifdef RIPPLE_GLITCH_COUNT_EN
            if (stab_q < STAB) begin
                glitch_d = sat_inc8(glitch_q);
            end
`endif
        end else if (stab_q < STAB) begin
            stab_d = stab_q + 4'd1;
            // A candidate that settles back on the published value produces no event.
            if ((stab_q + 4'd1 == STAB) && (cand_q != count_q)) begin
                count_d  = cand_q;
                delta_d  = mod_diff(cand_q, count_q);
                update_d = 1'b1;
                wrap_d   = (cand_q < count_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q     <= '0;
            s2_q     <= '0;
            cand_q   <= '0;
            stab_q   <= STAB;
            count_q  <= '0;
            delta_q  <= '0;
            update_q <= 1'b0;
            wrap_q   <= 1'b0;
`ifdef RIPPLE_GLITCH_COUNT_EN
            glitch_q <= 8'd0;
`endif
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            cand_q   <= cand_d;
            stab_q   <= stab_d;
            count_q  <= count_d;
            delta_q  <= delta_d;
            update_q <= update_d;
            wrap_q   <= wrap_d;
`ifdef RIPPLE_GLITCH_COUNT_EN
            glitch_q <= glitch_d;
`endif
        end
    end

    assign count_out = count_q;
    assign update    = update_q;
    assign delta     = delta_q;
    assign wrap      = wrap_q;
`ifdef RIPPLE_GLITCH_COUNT_EN
    assign glitch_cnt = glitch_q;
`endif

endmodule
